rx_engine_raw: RTL and testbench
================================

# rx_engine_raw

Receive-side MAC engine for the GMII byte interface. Strips preamble/SFD, checks CRC-32, holds back and discards the 4-byte FCS, and writes frame bytes plus one trailing status byte into the RX FIFO with SOF/EOF marking. It also maintains good-frame and dropped-frame counters. It sits between the PHY-side GMII receive registers and the RX FIFO consumed by the packet logic.

## Interface
- No parameters. Max frame length is selected at run time by `jumboframes`.
- `clk` in 1: single clock, GMII RX domain.
- `reset` in 1: asynchronous, active-high. Clears all state, counters and outputs.
- `jumboframes` in 1: max length incl. FCS is 9018 when 1, 1518 when 0.
- `int_rx_din` in 8: GMII receive data.
- `int_rx_dv` in 1: GMII data valid.
- `int_rx_er` in 1: GMII receive error.
- `rxff_full` in 1: RX FIFO full. A write is not allowed while high.
- `rxff_data` out 8: FIFO write data. Carries a frame byte or the status byte.
- `rxff_sof` out 1: marks the first word of a frame.
- `rxff_eof` out 1: marks the status word, which is the last word of a frame.
- `rxff_wren` out 1: FIFO write strobe.
- `rx_count` out 32: count of frames with status == 0. Wraps at 2^32.
- `rx_drop_count` out 32: count of frames with nonzero status plus frames dropped unseen. Wraps at 2^32.
- `debug` out 4: `{rxff_full, state[2:0]}`.

## Operation
- GMII inputs are registered once. The FSM acts on the registered copies (`dv_r`, `din_r`, `er_r`).
- **ST_IDLE**
  - `dv_r`=0: stay.
  - `dv_r`=1 and `din_r`=0x55: go to ST_PREAMBLE.
  - `dv_r`=1 and `din_r`=0xD5: go to ST_DATA.
  - `dv_r`=1 and any other byte: go to ST_DROP and increment `rx_drop_count`.
- **ST_PREAMBLE**
  - 0x55: stay.
  - 0xD5: go to ST_DATA. Clear the byte count, the flags and the CRC register (CRC := 0xFFFFFFFF).
  - `dv_r`=0: go to ST_IDLE. Nothing is counted.
  - Any other byte: go to ST_DROP and increment `rx_drop_count`.
- **ST_DATA**, for each byte with `dv_r`=1:
  - CRC-32 update: reflected, poly 0x04C11DB7, non-inverted register.
  - Byte count increments. The count is 14 bits and saturates at 16383.
  - The byte shifts into a 4-deep holdback line.
  - Once the line is full, the byte shifted out is written to the FIFO, subject to the "writing" condition below.
  - The first written byte carries `rxff_sof`=1.
- Flags, sticky per frame:
  - `er`: set if `er_r`=1 on any data byte.
  - `ovf`: set if `rxff_full` is high when a write is due.
  - `long`: set when the count exceeds the max length.
- "Writing" is stopped for the rest of the frame once `ovf` or `long` is set. Counting, CRC and flag evaluation continue.
- ST_DATA and `dv_r`=0: go to ST_STATUS. The 4 held bytes (the FCS) are discarded.
- **ST_STATUS**
  - Status byte bits:
    - bit0 `crc_bad`: set when the CRC register is not 0xDEBB20E3.
    - bit1 `er`.
    - bit2 `runt`: set when count < 64.
    - bit3 `long`.
    - bit4 `ovf`.
    - bits 7:5 are 0.
  - When `rxff_full`=0, write the status byte with `rxff_eof`=1.
  - `rxff_sof`=1 on the status byte if no data byte of the frame was written.
  - Increment `rx_count` if status==0, else increment `rx_drop_count`.
  - Then go to ST_IDLE if `dv_r`=0, else go to ST_DROP.
  - While `rxff_full`=1, hold in ST_STATUS. A frame arriving meanwhile is not received; on leaving ST_STATUS with `dv_r`=1, increment `rx_drop_count` once more.
- **ST_DROP**: no writes. Go to ST_IDLE on `dv_r`=0.

## Timing
- Reset values:
  - `rxff_wren`, `rxff_sof`, `rxff_eof` = 0.
  - `rxff_data` = 0x00.
  - Both counters = 0.
  - State = ST_IDLE.
- All FIFO outputs are registered.
- Data latency: data byte k (sampled at clock edge e_k) is written with `rxff_wren` high in the cycle after edge e_(k+4)+1. That is 2 clocks of pipeline plus 4 bytes of FCS holdback.
- Status latency: the status byte is written 2 clocks after the edge that samples `int_rx_dv`=0, when `rxff_full` is low. Otherwise it is written on the first cycle after `rxff_full` falls.
- `rxff_full` is sampled in the same cycle the write would be issued. A write is never asserted while `rxff_full` is high.
- Each frame produces at most one `rxff_sof` and exactly one `rxff_eof`, except frames that end in ST_DROP or are cut off by reset, which produce none.
- A `dv` gap inside a frame terminates the frame; there is no resynchronisation.
- Reset mid-frame:
  - Writing aborts immediately and no status is written.
  - If `dv` is high at release, the next sampled frame byte (not 0x55/0xD5) takes ST_IDLE to ST_DROP.
- Counters update on the cycle the status byte is written, or on the cycle of entry to ST_DROP.
- `int_rx_er` outside `dv` is ignored.

## Test plan
- **Good frame:** 7×0x55, 0xD5, 60 payload bytes 0x00..0x3B, correct FCS → 60 writes, SOF on 0x00, status 0x00 with EOF, `rx_count`=1.
- **Bad CRC:** same frame with the last FCS byte inverted → 60 data writes, status 0x01, `rx_drop_count`=1.
- **Runt:** 20 payload bytes with valid FCS → status 0x04. Then a 4-byte total frame → single word, SOF=EOF=1, status 0x05.
- **Oversize:** a 1600-byte frame with `jumboframes`=0 → writing stops after byte 1518, status bit3 set. With `jumboframes`=1 → status 0x00.
- **FIFO full:** hold `rxff_full` high from payload byte 10 to 30 cycles past frame end → bytes 0–9 written, status 0x10 written on the first cycle after full drops. A back-to-back frame sent meanwhile increments `rx_drop_count` (total 2) and produces no writes.
- **Error and reset:** `int_rx_er` pulse on byte 5 → status 0x02. Separately, assert `reset` mid-payload → outputs 0 and counters 0; the remainder of the frame produces no writes.

Source files
------------

// File: rtl/rx_engine_raw.sv
// rx_engine_raw
// Receive-side MAC engine between the GMII receive registers and the RX FIFO.
// It strips preamble/SFD, runs CRC-32 over every frame byte, holds back the
// last four bytes so the FCS never reaches the FIFO, and closes each frame
// with a status byte. It also counts good frames and dropped frames.
//
// Ports:
//   clk            GMII RX clock
//   reset          asynchronous active-high reset
//   jumboframes    1: max length 9018 (incl. FCS), 0: 1518
//   int_rx_din     GMII receive data
//   int_rx_dv      GMII data valid
//   int_rx_er      GMII receive error
//   rxff_full      RX FIFO full, no write may be issued while high
//   rxff_data      FIFO write data (frame byte or status byte)
//   rxff_sof       first word of a frame
//   rxff_eof       status word, last word of a frame
//   rxff_wren      FIFO write strobe
//   rx_count       frames closed with status 0
//   rx_drop_count  frames with bad status plus frames dropped unseen
//   debug          {rxff_full, state}
module rx_engine_raw (
  input  logic        clk,
  input  logic        reset,
  input  logic        jumboframes,
  input  logic [7:0]  int_rx_din,
  input  logic        int_rx_dv,
  input  logic        int_rx_er,
  input  logic        rxff_full,
  output logic [7:0]  rxff_data,
  output logic        rxff_sof,
  output logic        rxff_eof,
  output logic        rxff_wren,
  output logic [31:0] rx_count,
  output logic [31:0] rx_drop_count,
  output logic [3:0]  debug
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_STATUS   = 3'd3,
    ST_DROP     = 3'd4
  } state_t;

  // Register value left behind after a frame whose FCS is correct.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  state_t            state_q, state_d;
  logic              dvR_q, erR_q;
  logic [7:0]        dinR_q;
  logic [31:0]       crc_q, crc_d;
  logic [13:0]       byteCount_q, byteCount_d;
  logic [3:0][7:0]   hold_q, hold_d;
  logic              flagEr_q, flagEr_d;
  logic              flagOvf_q, flagOvf_d;
  logic              flagLong_q, flagLong_d;
  logic              sofPending_q, sofPending_d;
  logic              wren_q, wren_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic [7:0]        data_q, data_d;
  logic [31:0]       rxCount_q, rxCount_d;
  logic [31:0]       dropCount_q, dropCount_d;

  logic [13:0]       maxLen;
  logic [13:0]       countInc;
  logic              longNow;
  logic              writeDue;
  logic [7:0]        statusByte;

  // Reflected CRC-32 (poly 0x04C11DB7), one byte, LSB first, no inversion.
  function automatic logic [31:0] crcNext(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h000000, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Per-byte helper terms. The long check uses the updated count so that the
  // byte which pushes the frame over the limit already blocks its write.
  always_comb begin
    maxLen     = jumboframes ? 14'd9018 : 14'd1518;
    countInc   = (byteCount_q == 14'h3FFF) ? byteCount_q : byteCount_q + 14'd1;
    longNow    = flagLong_q | (countInc > maxLen);
    writeDue   = (byteCount_q >= 14'd4) && !flagOvf_q && !longNow;
    statusByte = {3'b000, flagOvf_q, flagLong_q, (byteCount_q < 14'd64),
                  flagEr_q, (crc_q != CRC_RESIDUE)};
  end

  // Next-state and output logic. FIFO strobes default low every cycle; frame
  // state is reset on every entry to ST_DATA so both SFD paths start clean.
  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    byteCount_d  = byteCount_q;
    hold_d       = hold_q;
    flagEr_d     = flagEr_q;
    flagOvf_d    = flagOvf_q;
    flagLong_d   = flagLong_q;
    sofPending_d = sofPending_q;
    wren_d       = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    data_d       = data_q;
    rxCount_d    = rxCount_q;
    dropCount_d  = dropCount_q;

    case (state_q)
      ST_IDLE, ST_PREAMBLE: begin
        if (!dvR_q) begin
          state_d = ST_IDLE;
        end else if (dinR_q == 8'h55) begin
          state_d = ST_PREAMBLE;
        end else if (dinR_q == 8'hD5) begin
          state_d      = ST_DATA;
          crc_d        = 32'hFFFFFFFF;
          byteCount_d  = '0;
          flagEr_d     = 1'b0;
          flagOvf_d    = 1'b0;
          flagLong_d   = 1'b0;
          sofPending_d = 1'b1;
        end else begin
          state_d     = ST_DROP;
          dropCount_d = dropCount_q + 32'd1;
        end
      end

      ST_DATA: begin
        if (dvR_q) begin
          crc_d       = crcNext(crc_q, dinR_q);
          byteCount_d = countInc;
          hold_d      = {hold_q[2:0], dinR_q};
          flagEr_d    = flagEr_q | erR_q;
          flagLong_d  = longNow;
          // hold_q[3] is the byte leaving the four-byte FCS holdback line.
          if (writeDue) begin
            if (rxff_full) begin
              flagOvf_d = 1'b1;
            end else begin
              wren_d       = 1'b1;
              data_d       = hold_q[3];
              sof_d        = sofPending_q;
              sofPending_d = 1'b0;
            end
          end
        end else begin
          state_d = ST_STATUS;
        end
      end

      ST_STATUS: begin
        // A frame that started while we waited here is lost; it is counted
        // as dropped on the way out.
        if (!rxff_full) begin
          wren_d       = 1'b1;
          eof_d        = 1'b1;
          sof_d        = sofPending_q;
          sofPending_d = 1'b0;
          data_d       = statusByte;
          rxCount_d    = rxCount_q + {31'd0, (statusByte == 8'h00)};
          dropCount_d  = dropCount_q + {31'd0, (statusByte != 8'h00)} + {31'd0, dvR_q};
          state_d      = dvR_q ? ST_DROP : ST_IDLE;
        end
      end

      ST_DROP: begin
        if (!dvR_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // GMII input stage plus all engine state. Reset drops any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvR_q        <= 1'b0;
      dinR_q       <= 8'h00;
      erR_q        <= 1'b0;
      state_q      <= ST_IDLE;
      crc_q        <= 32'hFFFFFFFF;
      byteCount_q  <= '0;
      hold_q       <= '0;
      flagEr_q     <= 1'b0;
      flagOvf_q    <= 1'b0;
      flagLong_q   <= 1'b0;
      sofPending_q <= 1'b0;
      wren_q       <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      data_q       <= 8'h00;
      rxCount_q    <= '0;
      dropCount_q  <= '0;
    end else begin
      dvR_q        <= int_rx_dv;
      dinR_q       <= int_rx_din;
      erR_q        <= int_rx_er;
      state_q      <= state_d;
      crc_q        <= crc_d;
      byteCount_q  <= byteCount_d;
      hold_q       <= hold_d;
      flagEr_q     <= flagEr_d;
      flagOvf_q    <= flagOvf_d;
      flagLong_q   <= flagLong_d;
      sofPending_q <= sofPending_d;
      wren_q       <= wren_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      data_q       <= data_d;
      rxCount_q    <= rxCount_d;
      dropCount_q  <= dropCount_d;
    end
  end

  assign rxff_data     = data_q;
  assign rxff_sof      = sof_q;
  assign rxff_eof      = eof_q;
  assign rxff_wren     = wren_q;
  assign rx_count      = rxCount_q;
  assign rx_drop_count = dropCount_q;
  assign debug         = {rxff_full, state_q};

endmodule

// File: tb/tb_rx_engine_raw.sv
// tb_rx_engine_raw
// Scoreboard bench for rx_engine_raw. Each stimulus step pushes the FIFO words
// it expects into expQ; a monitor pops and compares on every rxff_wren.
module tb_rx_engine_raw;

  logic        clk;
  logic        reset;
  logic        jumboframes;
  logic [7:0]  int_rx_din;
  logic        int_rx_dv;
  logic        int_rx_er;
  logic        rxff_full;
  logic [7:0]  rxff_data;
  logic        rxff_sof;
  logic        rxff_eof;
  logic        rxff_wren;
  logic [31:0] rx_count;
  logic [31:0] rx_drop_count;
  logic [3:0]  debug;

  int          checks = 0;
  int          passes = 0;
  logic [7:0]  frm[$];
  logic [9:0]  expQ[$];
  logic [9:0]  expWord;

  rx_engine_raw dut (
    .clk           (clk),
    .reset         (reset),
    .jumboframes   (jumboframes),
    .int_rx_din    (int_rx_din),
    .int_rx_dv     (int_rx_dv),
    .int_rx_er     (int_rx_er),
    .rxff_full     (rxff_full),
    .rxff_data     (rxff_data),
    .rxff_sof      (rxff_sof),
    .rxff_eof      (rxff_eof),
    .rxff_wren     (rxff_wren),
    .rx_count      (rx_count),
    .rx_drop_count (rx_drop_count),
    .debug         (debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a stuck run still ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Reference CRC-32 (IEEE 802.3, reflected).
  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic buildPayload(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'(i));
  endtask

  task automatic appendFcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (frm[i]) c = crcByte(c, frm[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  // Words the FIFO should see: the first nWritten bytes of frm, then status.
  task automatic expectFrame(input int nWritten, input logic [7:0] status);
    for (int i = 0; i < nWritten; i++) expQ.push_back({(i == 0), 1'b0, frm[i]});
    expQ.push_back({(nWritten == 0), 1'b1, status});
  endtask

  // Drives 7x0x55, 0xD5, then frm; er on byte erIdx, FIFO full from byte fullIdx.
  // Returns right after driving dv low.
  task automatic applyStimulus(input int erIdx, input int fullIdx);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      int_rx_dv  = 1'b1;
      int_rx_er  = 1'b0;
      int_rx_din = (i == 7) ? 8'hD5 : 8'h55;
    end
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clk);
      int_rx_din = frm[i];
      int_rx_er  = (i == erIdx);
      if (i == fullIdx) rxff_full = 1'b1;
    end
    @(negedge clk);
    int_rx_dv  = 1'b0;
    int_rx_er  = 1'b0;
    int_rx_din = 8'h00;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (expQ.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (8) @(negedge clk);
    checkOutput({name, " words pending"}, 32'(expQ.size()), 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rxff_wren) begin
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected write: got sof=%0b eof=%0b data=0x%02h, required no write",
                 rxff_sof, rxff_eof, rxff_data);
      end else begin
        expWord = expQ.pop_front();
        checkOutput("fifo word", {22'd0, rxff_sof, rxff_eof, rxff_data}, {22'd0, expWord});
      end
    end
  end

  initial begin
    bit released;
    released    = 1'b0;
    reset       = 1'b1;
    jumboframes = 1'b0;
    int_rx_din  = 8'h00;
    int_rx_dv   = 1'b0;
    int_rx_er   = 1'b0;
    rxff_full   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset wren/sof/eof", {29'd0, rxff_wren, rxff_sof, rxff_eof}, 32'd0);
    checkOutput("reset data", {24'd0, rxff_data}, 32'd0);
    checkOutput("reset rx_count", rx_count, 32'd0);
    checkOutput("reset drop_count", rx_drop_count, 32'd0);
    checkOutput("reset debug", {28'd0, debug}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] good frame");
    buildPayload(60); appendFcs();
    expectFrame(60, 8'h00);
    applyStimulus(-1, -1);
    repeat (3) @(negedge clk);
    checkOutput("status latency", {30'd0, rxff_wren, rxff_eof}, 32'd3);
    drain("good");
    checkOutput("good rx_count", rx_count, 32'd1);
    checkOutput("good drop_count", rx_drop_count, 32'd0);

    $display("[TB] bad crc");
    buildPayload(60); appendFcs();
    frm[63] = ~frm[63];
    expectFrame(60, 8'h01);
    applyStimulus(-1, -1);
    drain("badcrc");
    checkOutput("badcrc drop_count", rx_drop_count, 32'd1);
    checkOutput("badcrc rx_count", rx_count, 32'd1);

    $display("[TB] runts");
    buildPayload(20); appendFcs();
    expectFrame(20, 8'h04);
    applyStimulus(-1, -1);
    drain("runt20");
    frm.delete();
    frm.push_back(8'h11); frm.push_back(8'h22); frm.push_back(8'h33); frm.push_back(8'h44);
    expectFrame(0, 8'h05);
    applyStimulus(-1, -1);
    drain("runt4");
    checkOutput("runt drop_count", rx_drop_count, 32'd3);

    $display("[TB] oversize");
    buildPayload(1596); appendFcs();
    expectFrame(1514, 8'h08);
    applyStimulus(-1, -1);
    drain("long");
    checkOutput("long drop_count", rx_drop_count, 32'd4);
    jumboframes = 1'b1;
    expectFrame(1596, 8'h00);
    applyStimulus(-1, -1);
    drain("jumbo");
    checkOutput("jumbo rx_count", rx_count, 32'd2);
    jumboframes = 1'b0;

    $display("[TB] fifo full");
    pulseReset();
    repeat (2) @(negedge clk);
    buildPayload(60); appendFcs();
    expectFrame(10, 8'h10);
    // Full rises exactly when payload byte 10 is due to be written.
    applyStimulus(-1, 15);
    repeat (4) @(negedge clk);
    for (int j = 0; j < 72; j++) begin
      @(negedge clk);
      if (released) begin
        checkOutput("status after full drop", {30'd0, rxff_wren, rxff_eof}, 32'd3);
        released = 1'b0;
      end
      if (j == 20) checkOutput("debug while full", {28'd0, debug}, 32'hB);
      int_rx_dv  = 1'b1;
      int_rx_din = (j < 7) ? 8'h55 : ((j == 7) ? 8'hD5 : frm[j-8]);
      if (j == 25) begin
        rxff_full = 1'b0;
        released  = 1'b1;
      end
    end
    @(negedge clk);
    int_rx_dv = 1'b0;
    drain("full");
    checkOutput("full drop_count", rx_drop_count, 32'd2);
    checkOutput("full rx_count", rx_count, 32'd0);

    $display("[TB] rx error");
    buildPayload(60); appendFcs();
    expectFrame(60, 8'h02);
    applyStimulus(5, -1);
    drain("er");
    checkOutput("er drop_count", rx_drop_count, 32'd3);

    $display("[TB] reset mid-frame");
    buildPayload(60); appendFcs();
    for (int i = 0; i < 15; i++) expQ.push_back({(i == 0), 1'b0, frm[i]});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      int_rx_dv  = 1'b1;
      int_rx_din = (i == 7) ? 8'hD5 : 8'h55;
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 22) begin
        checkOutput("midreset wren/sof/eof", {29'd0, rxff_wren, rxff_sof, rxff_eof}, 32'd0);
        checkOutput("midreset data", {24'd0, rxff_data}, 32'd0);
        checkOutput("midreset drop_count", rx_drop_count, 32'd0);
      end
      int_rx_din = frm[i];
      if (i == 20) begin
        #1 reset = 1'b1;
      end
      if (i == 24) reset = 1'b0;
    end
    @(negedge clk);
    int_rx_dv = 1'b0;
    drain("midreset");
    checkOutput("midreset drop after release", rx_drop_count, 32'd1);
    checkOutput("midreset rx_count", rx_count, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
